// File: rtl/gpio_chk_pkg.sv
// Shared state type, default sizes and slice helper for the GPIO loopback count checker.
package gpio_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } chk_state_e;

    localparam int DEF_NUM_CH = 5;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_ERR_W  = 16;

    // Widest packed vector and widest channel the slice helper handles.
    localparam int MAX_VEC_W  = 512;
    localparam int MAX_CH_W   = 64;

    function automatic logic [MAX_CH_W-1:0] ch_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   ch,
        input int                   w
    );
        return MAX_CH_W'(vec >> (ch * w));
    endfunction

endpackage

// File: rtl/gpio_chk_ch.sv
// One checker channel: window compare, sticky fail, saturating fail count.
// GPIO_CNT_CHECK_STUCK_EN adds the sticky zero-count (STUCK) detector.
module gpio_chk_ch
    import gpio_chk_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] cnt_min,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic             result_en,
    input  logic             clr,
    output logic             pass_now,
    output logic             pass,
    output logic             err_sticky,
    output logic             stuck,
    output logic [ERR_W-1:0] err_cnt
);

    logic             zero_s;
    logic             pass_s;
    logic             fail_s;
    logic             pass_r;
    logic             sticky_r;
    logic             sticky_nxt_s;
    logic [ERR_W-1:0] err_cnt_r;
    logic [ERR_W-1:0] err_base_s;
    logic [ERR_W-1:0] err_nxt_s;

`ifdef GPIO_CNT_CHECK_STUCK_EN
    logic stuck_r;

    assign zero_s = (cnt == {CNT_W{1'b0}});

    // Sticky zero-count flag; a clear in the same cycle is applied first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stuck_r <= 1'b0;
        end else begin
            stuck_r <= (clr ? 1'b0 : stuck_r) | (result_en & zero_s);
        end
    end

    assign stuck = stuck_r;
`else
    assign zero_s = 1'b0;
    assign stuck  = 1'b0;
`endif

    // An inverted window (min > max) can never satisfy both bounds.
    assign pass_s   = (cnt >= cnt_min) && (cnt <= cnt_max) && !zero_s;
    assign fail_s   = result_en && !pass_s;
    assign pass_now = pass_s;

    // Clear first, then fold in this window's result.
    always_comb begin
        err_base_s   = clr ? {ERR_W{1'b0}} : err_cnt_r;
        sticky_nxt_s = (clr ? 1'b0 : sticky_r) | fail_s;
        if (fail_s && (err_base_s != {ERR_W{1'b1}})) begin
            err_nxt_s = err_base_s + ERR_W'(1'b1);
        end else begin
            err_nxt_s = err_base_s;
        end
    end

    // Result registers for this channel.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pass_r    <= 1'b0;
            sticky_r  <= 1'b0;
            err_cnt_r <= {ERR_W{1'b0}};
        end else begin
            pass_r    <= result_en ? pass_s : pass_r;
            sticky_r  <= sticky_nxt_s;
            err_cnt_r <= err_nxt_s;
        end
    end

    assign pass       = pass_r;
    assign err_sticky = sticky_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: rtl/gpio_cnt_check.sv
// GPIO loopback count checker: settle/run FSM, sample pipeline, window count and lock.
// Optional zero-count detection per channel is built with GPIO_CNT_CHECK_STUCK_EN.
module gpio_cnt_check
    import gpio_chk_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ERR_W      = DEF_ERR_W,
    parameter int SETTLE_WIN = 2,
    parameter int LOCK_WIN   = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    TIMER_1S,
    input  logic [NUM_CH*CNT_W-1:0] CNT_IN,
    input  logic [NUM_CH*CNT_W-1:0] CNT_MIN,
    input  logic [NUM_CH*CNT_W-1:0] CNT_MAX,
    input  logic                    START,
    input  logic                    STOP,
    input  logic                    CLR,
    output logic                    BUSY,
    output logic                    LOCKED,
    output logic                    RESULT_VLD,
    output logic [NUM_CH-1:0]       PASS,
    output logic [NUM_CH-1:0]       ERR_STICKY,
    output logic [NUM_CH*ERR_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0]        WIN_CNT,
    output logic [NUM_CH-1:0]       STUCK
);

    localparam int SET_W  = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
    localparam int LOCK_W = $clog2(LOCK_WIN + 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'((SETTLE_WIN > 0) ? SETTLE_WIN - 1 : 0);
    localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCK_WIN);

    chk_state_e       state_r;
    chk_state_e       state_nxt_s;
    logic [SET_W-1:0] settle_cnt_r;
    logic [SET_W-1:0] settle_nxt_s;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic [LOCK_W-1:0] lock_nxt_s;
    logic             sample_r;
    logic             sample_nxt_s;
    logic             result_en_s;
    logic             result_vld_r;
    logic             locked_r;
    logic             busy_r;
    logic [CNT_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] win_nxt_s;
    logic [NUM_CH-1:0] ch_pass_s;
    logic             all_pass_s;

    // CNT_IN is latched one cycle after TIMER_1S, so compare on the delayed pulse.
    assign sample_nxt_s = TIMER_1S && (state_r == RUN) && !STOP;
    assign result_en_s  = sample_r && !STOP;
    assign all_pass_s   = &ch_pass_s;
    assign win_nxt_s    = (CLR ? {CNT_W{1'b0}} : win_cnt_r) + (result_en_s ? CNT_W'(1'b1) : CNT_W'(1'b0));

    // Next-state and settle counter.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_cnt_r;
        if (STOP) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (START) begin
                        settle_nxt_s = {SET_W{1'b0}};
                        state_nxt_s  = (SETTLE_WIN == 0) ? RUN : SETTLE;
                    end else begin
                        state_nxt_s  = IDLE;
                    end
                end
                SETTLE: begin
                    if (TIMER_1S) begin
                        if (settle_cnt_r == SETTLE_LAST) begin
                            state_nxt_s = RUN;
                        end else begin
                            settle_nxt_s = settle_cnt_r + SET_W'(1'b1);
                        end
                    end else begin
                        state_nxt_s = SETTLE;
                    end
                end
                RUN:     state_nxt_s = RUN;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Consecutive all-pass run length, saturating at the lock threshold.
    always_comb begin
        lock_nxt_s = lock_cnt_r;
        if (STOP || ((state_r == IDLE) && START)) begin
            lock_nxt_s = {LOCK_W{1'b0}};
        end else if (result_en_s && !all_pass_s) begin
            lock_nxt_s = {LOCK_W{1'b0}};
        end else if (result_en_s && (lock_cnt_r != LOCK_MAX)) begin
            lock_nxt_s = lock_cnt_r + LOCK_W'(1'b1);
        end else begin
            lock_nxt_s = lock_cnt_r;
        end
    end

    // Control state, sample pipeline and registered status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= IDLE;
            settle_cnt_r <= {SET_W{1'b0}};
            lock_cnt_r   <= {LOCK_W{1'b0}};
            sample_r     <= 1'b0;
            result_vld_r <= 1'b0;
            locked_r     <= 1'b0;
            busy_r       <= 1'b0;
            win_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_nxt_s;
            lock_cnt_r   <= lock_nxt_s;
            sample_r     <= sample_nxt_s;
            result_vld_r <= result_en_s;
            locked_r     <= (lock_nxt_s == LOCK_MAX);
            busy_r       <= (state_nxt_s != IDLE);
            win_cnt_r    <= win_nxt_s;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gpio_chk_ch #(
            .CNT_W (CNT_W),
            .ERR_W (ERR_W)
        ) u_ch (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .cnt        (CNT_W'(ch_slice(MAX_VEC_W'(CNT_IN),  c, CNT_W))),
            .cnt_min    (CNT_W'(ch_slice(MAX_VEC_W'(CNT_MIN), c, CNT_W))),
            .cnt_max    (CNT_W'(ch_slice(MAX_VEC_W'(CNT_MAX), c, CNT_W))),
            .result_en  (result_en_s),
            .clr        (CLR),
            .pass_now   (ch_pass_s[c]),
            .pass       (PASS[c]),
            .err_sticky (ERR_STICKY[c]),
            .stuck      (STUCK[c]),
            .err_cnt    (ERR_CNT[c*ERR_W +: ERR_W])
        );
    end

    assign BUSY       = busy_r;
    assign LOCKED     = locked_r;
    assign RESULT_VLD = result_vld_r;
    assign WIN_CNT    = win_cnt_r;

endmodule
